// File: rtl/timer_pkg.sv
// Shared types for the timer compare stage: FSM states and count modes.
package timer_pkg;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} timer_state_e;

    typedef enum logic {ONESHOT = 1'b0, PERIODIC = 1'b1} timer_mode_e;

endpackage : timer_pkg

// File: rtl/timer_compare_unit.sv
// Period/compare back end of the core timer: counts prescaled ticks up to a
// shadowed period in one-shot or periodic mode, with compare, overflow and sticky IRQ.
module timer_compare_unit
    import timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             tick_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] period_i,
    input  logic [WIDTH-1:0] cmp_i,
    input  logic             irq_clr_i,
    output logic [WIDTH-1:0] count_o,
    output logic             running_o,
    output logic             ovf_o,
    output logic             cmp_match_o,
    output logic             irq_o
);

    timer_state_e     state_r;
    timer_state_e     next_state_s;
    timer_mode_e      shadow_mode_r;
    logic [WIDTH-1:0] shadow_period_r;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             ovf_r;
    logic             cmp_match_r;
    logic             irq_r;

    logic             start_acc_s;
    logic             tick_en_s;
    logic             period_evt_s;
    logic             wrap_s;
    logic             cmp_wr_s;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; stop always beats start
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i && !stop_i) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (stop_i) begin
                    next_state_s = IDLE;
                end else if (start_i) begin
                    next_state_s = RUN;
                end else if (period_evt_s && (shadow_mode_r == ONESHOT)) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RUN;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Per-cycle control decode; a restart takes precedence over a coincident tick
    always_comb begin
        start_acc_s  = start_i && !stop_i;
        tick_en_s    = (state_r == RUN) && tick_i && !stop_i && !start_i;
        period_evt_s = tick_en_s && (count_r == shadow_period_r);
        wrap_s       = period_evt_s && (shadow_mode_r == PERIODIC);
        // The one-shot terminal hold writes nothing new, so it cannot match
        cmp_wr_s     = tick_en_s && !(period_evt_s && (shadow_mode_r == ONESHOT));
    end

    // Next count value
    always_comb begin
        count_nxt_s = count_r;
        if (start_acc_s) begin
            count_nxt_s = {WIDTH{1'b0}};
        end else if (tick_en_s) begin
            if (period_evt_s) begin
                if (shadow_mode_r == PERIODIC) begin
                    count_nxt_s = {WIDTH{1'b0}};
                end else begin
                    count_nxt_s = count_r;
                end
            end else begin
                count_nxt_s = count_r + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Datapath: count, shadow configuration and event pulses
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_r         <= {WIDTH{1'b0}};
            shadow_period_r <= {WIDTH{1'b0}};
            shadow_mode_r   <= ONESHOT;
            ovf_r           <= 1'b0;
            cmp_match_r     <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            ovf_r       <= period_evt_s;
            cmp_match_r <= cmp_wr_s && (count_nxt_s == cmp_i);
            if (start_acc_s || wrap_s) begin
                shadow_period_r <= period_i;
                shadow_mode_r   <= timer_mode_e'(mode_i);
            end else begin
                shadow_period_r <= shadow_period_r;
                shadow_mode_r   <= shadow_mode_r;
            end
        end
    end

    // Sticky interrupt; a period event beats a coincident clear
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            irq_r <= 1'b0;
        end else if (period_evt_s) begin
            irq_r <= 1'b1;
        end else if (irq_clr_i) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_r;
        end
    end

    assign count_o     = count_r;
    assign running_o   = (state_r == RUN);
    assign ovf_o       = ovf_r;
    assign cmp_match_o = cmp_match_r;
    assign irq_o       = irq_r;

endmodule : timer_compare_unit

// File: tb/tb_timer_compare_unit.sv
// Directed self-checking bench for timer_compare_unit (WIDTH = 8).
module tb_timer_compare_unit;

    localparam int W = 8;

    logic         clk_i;
    logic         rst_n_i;
    logic         tick_i;
    logic         start_i;
    logic         stop_i;
    logic         mode_i;
    logic [W-1:0] period_i;
    logic [W-1:0] cmp_i;
    logic         irq_clr_i;
    logic [W-1:0] count_o;
    logic         running_o;
    logic         ovf_o;
    logic         cmp_match_o;
    logic         irq_o;

    int checks = 0;
    int errors = 0;

    timer_compare_unit #(.WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .tick_i      (tick_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .mode_i      (mode_i),
        .period_i    (period_i),
        .cmp_i       (cmp_i),
        .irq_clr_i   (irq_clr_i),
        .count_o     (count_o),
        .running_o   (running_o),
        .ovf_o       (ovf_o),
        .cmp_match_o (cmp_match_o),
        .irq_o       (irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // count, running, ovf, cmp_match, irq in one call
    task automatic chk_all(input string tag, input logic [W-1:0] c, input logic r,
                           input logic o, input logic m, input logic i);
        chkw({tag, ".count"}, count_o, c);
        chk1({tag, ".running"}, running_o, r);
        chk1({tag, ".ovf"}, ovf_o, o);
        chk1({tag, ".cmp"}, cmp_match_o, m);
        chk1({tag, ".irq"}, irq_o, i);
    endtask

    initial begin
        rst_n_i   = 1'b0;
        tick_i    = 1'b0;
        start_i   = 1'b0;
        stop_i    = 1'b0;
        mode_i    = 1'b0;
        period_i  = 8'd0;
        cmp_i     = 8'd0;
        irq_clr_i = 1'b0;
        #12;
        chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n_i = 1'b1;
        cyc();
        chk_all("idle", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Periodic wrap: period 3, compare 2
        period_i = 8'd3; cmp_i = 8'd2; mode_i = 1'b1; start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        chk_all("per.start", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick_i = 1'b1;
        cyc(); chk_all("per.c1", 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(); chk_all("per.c2", 8'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(); chk_all("per.c3", 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(); chk_all("per.wrap", 8'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc(); chk_all("per.c1b", 8'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick_i = 1'b0; stop_i = 1'b1;
        cyc();
        stop_i = 1'b0;
        chk_all("per.stop", 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        irq_clr_i = 1'b1;
        cyc();
        irq_clr_i = 1'b0;
        chk1("per.irqclr", irq_o, 1'b0);

        // One-shot: period 2, compare 2
        period_i = 8'd2; cmp_i = 8'd2; mode_i = 1'b0; start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        chk_all("os.start", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick_i = 1'b1;
        cyc(); chk_all("os.c1", 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(); chk_all("os.c2", 8'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(); chk_all("os.evt", 8'd2, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(); chk_all("os.hold1", 8'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(); chk_all("os.hold2", 8'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        tick_i = 1'b0; irq_clr_i = 1'b1;
        cyc();
        irq_clr_i = 1'b0;
        chk1("os.irqclr", irq_o, 1'b0);

        // Stop and restart
        period_i = 8'd10; cmp_i = 8'd255; mode_i = 1'b1; start_i = 1'b1;
        cyc();
        start_i = 1'b0; tick_i = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        chkw("sr.count5", count_o, 8'd5);
        stop_i = 1'b1;
        cyc();
        stop_i = 1'b0;
        chk_all("sr.stop", 8'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(); cyc();
        chkw("sr.hold", count_o, 8'd5);
        start_i = 1'b1; stop_i = 1'b1;
        cyc();
        stop_i = 1'b0;
        chk_all("sr.both", 8'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        start_i = 1'b0; tick_i = 1'b0;
        chk_all("sr.restart", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Shadow period and IRQ precedence
        period_i = 8'd4; start_i = 1'b1;
        cyc();
        start_i = 1'b0; tick_i = 1'b1;
        cyc(); cyc();
        chkw("sh.c2", count_o, 8'd2);
        period_i = 8'd1;
        cyc(); chkw("sh.c3", count_o, 8'd3);
        cyc(); chk_all("sh.c4", 8'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(); chk_all("sh.wrap4", 8'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        irq_clr_i = 1'b1;
        cyc(); chk_all("sh.clr", 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(); chk_all("sh.wrap1", 8'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc(); chk_all("sh.clr2", 8'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        irq_clr_i = 1'b0; tick_i = 1'b0; stop_i = 1'b1;
        cyc();
        stop_i = 1'b0;
        chk1("sh.stop", running_o, 1'b0);

        // Period 0 then asynchronous reset mid-run
        period_i = 8'd0; cmp_i = 8'd85; mode_i = 1'b1; start_i = 1'b1;
        cyc();
        start_i = 1'b0; tick_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_all("p0.tick", 8'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        end
        rst_n_i = 1'b0;
        #1;
        chk_all("rst.mid", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        cyc(); cyc();
        chk_all("rst.idle", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_timer_compare_unit
